// File: rtl/sprite_line_fetch_if.sv
// Sprite line fetch bus.
//   master : print controller side. Drives sprite_on, sprite_datas, pixel_tick.
//   slave  : fetch engine side. Drives memory_address, pixel_valid,
//            count_finished, busy.
interface sprite_line_fetch_if #(
    parameter int SIZE_ADDRESS = 14
);
    logic                    sprite_on;
    logic [31:0]             sprite_datas;
    logic                    pixel_tick;
    logic [SIZE_ADDRESS-1:0] memory_address;
    logic                    pixel_valid;
    logic                    count_finished;
    logic                    busy;

    modport master (
        output sprite_on, sprite_datas, pixel_tick,
        input  memory_address, pixel_valid, count_finished, busy
    );

    modport slave (
        input  sprite_on, sprite_datas, pixel_tick,
        output memory_address, pixel_valid, count_finished, busy
    );
endinterface

// File: rtl/sprite_line_fetch.sv
// Sprite line fetch engine.
// Started by the print controller's sprite_on. It generates sprite-memory
// addresses for the rest of one sprite row, advancing one address per
// pixel_tick. When the row segment is exhausted it raises count_finished and
// holds it until sprite_on drops.
// Ports:
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : sprite_line_fetch_if.slave
//                in : sprite_on (level request), sprite_datas (descriptor:
//                     [13:0] base, [18:14] col, [23:19] row), pixel_tick
//                out: memory_address, pixel_valid, count_finished, busy
module sprite_line_fetch #(
    parameter int SIZE_ADDRESS = 14,
    parameter int SPRITE_W     = 20,
    parameter int SPRITE_H     = 20
) (
    input  logic                clk,
    input  logic                reset,
    sprite_line_fetch_if.slave  bus
);
    localparam int REM_W  = $clog2(SPRITE_W + 1);
    localparam int PROD_W = 5 + REM_W;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                  state_q;
    logic [SIZE_ADDRESS-1:0] base_q;
    logic [SIZE_ADDRESS-1:0] addr_q;
    logic [4:0]              col_q;
    logic [4:0]              row_q;
    logic [REM_W-1:0]        rem_q;
    logic                    valid_q;
    logic                    fin_q;
    logic                    busy_q;

    // Row offset is a constant multiply. It is carried at full width, and
    // the sum wraps modulo 2^SIZE_ADDRESS.
    logic [PROD_W-1:0]       row_off;
    logic [SIZE_ADDRESS-1:0] start_d;
    logic [REM_W-1:0]        rem_d;
    logic                    in_range;

    assign row_off  = PROD_W'(row_q) * PROD_W'(SPRITE_W);
    assign start_d  = base_q + SIZE_ADDRESS'(row_off) + SIZE_ADDRESS'(col_q);
    assign rem_d    = REM_W'(SPRITE_W - int'(col_q));
    assign in_range = (32'(col_q) < SPRITE_W) && (32'(row_q) < SPRITE_H);

    // Descriptor bits [31:24] carry no meaning for this block.
    logic unused_hi;
    assign unused_hi = ^bus.sprite_datas[31:24];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            fin_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.sprite_on) begin
                        base_q  <= SIZE_ADDRESS'(bus.sprite_datas[13:0]);
                        col_q   <= bus.sprite_datas[18:14];
                        row_q   <= bus.sprite_datas[23:19];
                        busy_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    // pixel_tick is ignored here. Counting starts in RUN.
                    if (!bus.sprite_on) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (in_range) begin
                        addr_q  <= start_d;
                        rem_q   <= rem_d;
                        valid_q <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        fin_q   <= 1'b1;
                        state_q <= DONE;
                    end
                end
                RUN: begin
                    if (!bus.sprite_on) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (bus.pixel_tick) begin
                        if (rem_q == REM_W'(1)) begin
                            valid_q <= 1'b0;
                            fin_q   <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            addr_q <= addr_q + SIZE_ADDRESS'(1);
                            rem_q  <= rem_q - REM_W'(1);
                        end
                    end
                end
                DONE: begin
                    // Stay here until the controller drops its request. A new
                    // request is only accepted from IDLE.
                    if (!bus.sprite_on) begin
                        fin_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.memory_address = addr_q;
    assign bus.pixel_valid    = valid_q;
    assign bus.count_finished = fin_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_sprite_line_fetch.sv
module tb_sprite_line_fetch;
    localparam int SA = 14;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    sprite_line_fetch_if #(.SIZE_ADDRESS(SA)) bus ();

    sprite_line_fetch #(.SIZE_ADDRESS(SA), .SPRITE_W(20), .SPRITE_H(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] desc(input int base, input int row, input int col);
        return {8'hA5, row[4:0], col[4:0], base[13:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic v, input logic f, input logic b);
        chk({tag, ".valid"}, 32'(bus.pixel_valid), 32'(v));
        chk({tag, ".fin"},   32'(bus.count_finished), 32'(f));
        chk({tag, ".busy"},  32'(bus.busy), 32'(b));
    endtask

    task automatic chk_addr(input string tag, input int exp);
        chk({tag, ".addr"}, 32'(bus.memory_address), 32'(exp));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus.sprite_on    = 1'b0;
        bus.sprite_datas = '0;
        bus.pixel_tick   = 1'b0;
        step();
        step();
        chk_flags("reset", 0, 0, 0);
        chk_addr("reset", 0);
        reset = 1'b0;
        step();

        // Out of range, col = 20.
        bus.sprite_on = 1'b1;
        bus.sprite_datas = desc(100, 0, 20);
        step();
        chk_flags("oor_col_load", 0, 0, 1);
        step();
        chk_flags("oor_col_done", 0, 1, 1);
        chk_addr("oor_col_done", 0);
        bus.sprite_on = 1'b0;
        step();
        chk_flags("oor_col_idle", 0, 0, 0);
        step();

        // Out of range, row = 25.
        bus.sprite_on = 1'b1;
        bus.sprite_datas = desc(100, 25, 0);
        step();
        chk_flags("oor_row_load", 0, 0, 1);
        step();
        chk_flags("oor_row_done", 0, 1, 1);
        chk_addr("oor_row_done", 0);
        bus.sprite_on = 1'b0;
        step();
        chk_flags("oor_row_idle", 0, 0, 0);

        // Normal row: 100 + 2*20 + 15 = 155, 5 pixels. A tick during LOAD is ignored.
        bus.sprite_on = 1'b1;
        bus.pixel_tick = 1'b1;
        bus.sprite_datas = desc(100, 2, 15);
        step();
        chk_flags("norm_load", 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk_flags("norm_run", 1, 0, 1);
            chk_addr("norm_run", 155 + i);
        end
        step();
        chk_flags("norm_done", 0, 1, 1);
        chk_addr("norm_done", 159);
        step();
        chk_flags("norm_done_hold", 0, 1, 1);
        bus.sprite_on = 1'b0;
        step();
        chk_flags("norm_idle", 0, 0, 0);

        // Tick gating: col 18 leaves 2 pixels. A tick every 4th cycle holds each address 4 cycles.
        bus.pixel_tick = 1'b0;
        bus.sprite_on = 1'b1;
        bus.sprite_datas = desc(0, 0, 18);
        step();
        step();
        for (int k = 0; k < 8; k++) begin
            chk_flags("gate_run", 1, 0, 1);
            chk_addr("gate_run", (k < 4) ? 18 : 19);
            bus.pixel_tick = (k % 4 == 3);
            step();
        end
        bus.pixel_tick = 1'b0;
        chk_flags("gate_done", 0, 1, 1);
        chk_addr("gate_done", 19);
        bus.sprite_on = 1'b0;
        step();
        chk_flags("gate_idle", 0, 0, 0);

        // Wrap-around: 16380..16383, then 0..15.
        bus.pixel_tick = 1'b1;
        bus.sprite_on = 1'b1;
        bus.sprite_datas = desc(16380, 0, 0);
        step();
        for (int i = 0; i < 20; i++) begin
            step();
            chk_flags("wrap_run", 1, 0, 1);
            chk_addr("wrap_run", (16380 + i) % 16384);
        end
        step();
        chk_flags("wrap_done", 0, 1, 1);
        chk_addr("wrap_done", 15);
        bus.sprite_on = 1'b0;
        step();

        // Abort after 3 pixels: no count_finished.
        bus.sprite_on = 1'b1;
        bus.sprite_datas = desc(100, 2, 15);
        step();
        step();
        step();
        step();
        chk_addr("abort_run", 157);
        bus.sprite_on = 1'b0;
        step();
        chk_flags("abort_idle", 0, 0, 0);
        step();
        chk_flags("abort_idle2", 0, 0, 0);

        // Asynchronous reset mid-RUN.
        bus.sprite_on = 1'b1;
        step();
        step();
        step();
        chk_addr("rst_run", 156);
        #3;
        reset = 1'b1;
        #1;
        chk_flags("rst_async", 0, 0, 0);
        chk_addr("rst_async", 0);
        @(posedge clk);
        #1;
        chk_flags("rst_hold", 0, 0, 0);
        reset = 1'b0;
        bus.sprite_on = 1'b0;
        step();
        chk_flags("rst_idle", 0, 0, 0);

        // Back-to-back: sprite_on held after DONE gives no restart.
        bus.sprite_on = 1'b1;
        bus.sprite_datas = desc(0, 0, 18);
        step();
        step();
        chk_addr("b2b_a", 18);
        step();
        chk_addr("b2b_a", 19);
        step();
        chk_flags("b2b_done", 0, 1, 1);
        bus.sprite_datas = desc(40, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_flags("b2b_norestart", 0, 1, 1);
            chk_addr("b2b_norestart", 19);
        end
        bus.sprite_on = 1'b0;
        step();
        chk_flags("b2b_idle", 0, 0, 0);
        bus.sprite_on = 1'b1;
        step();
        chk_flags("b2b_load", 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            step();
            chk_flags("b2b_run", 1, 0, 1);
            chk_addr("b2b_run", 60 + i);
        end
        step();
        chk_flags("b2b_done2", 0, 1, 1);
        chk_addr("b2b_done2", 79);
        bus.sprite_on = 1'b0;
        step();
        chk_flags("b2b_idle2", 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
